uart_cmd_bridge: RTL and testbench

UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

---
 rtl/uart_bridge_pkg.sv | 22 ++
 rtl/bridge_timer.sv | 35 +++
 rtl/uart_cmd_bridge.sv | 185 ++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared constants and FSM state type for the UART command bridge
//
// Opcodes:   OP_WRITE (0x57 'W'), OP_READ (0x52 'R')
// Responses: RSP_ACK  (0x4B 'K'), RSP_ERR (0x3F '?')
package uart_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS_WR,
        BUS_RD,
        RD_WAIT,
        SEND
    } state_t;

endpackage

// File: rtl/bridge_timer.sv
// rtl/bridge_timer.sv - inter-byte timeout counter for the UART command bridge
//
// Parameter: TIMEOUT  cycles to expiry; 0 disables expiry
// Ports:     clk, rst (async, active-high)
//            clear    zero the count (wins over enable)
//            enable   count this cycle (waiting for a byte)
//            expired  combinational: enable is high and the count has reached TIMEOUT-1
module bridge_timer #(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [31:0] LIMIT = 32'(TIMEOUT) - 32'd1;

    logic [31:0] count;

    // The count saturates at LIMIT so a disabled timer (TIMEOUT=0) never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
        end else if (clear) begin
            count <= 32'd0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 32'd1;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/uart_cmd_bridge.sv
// rtl/uart_cmd_bridge.sv - UART byte-stream to register-bus command bridge
//
// Parameter: TIMEOUT   inter-byte timeout in clk cycles (0 disables)
// Ports:     clk, rst                 clock, async active-high reset
//            rx_empty, r_data, rd_uart  receive FIFO head and pop
//            tx_full, wr_uart, w_data   transmit FIFO push and response byte
//            bus_addr, bus_wdata, bus_we, bus_re, bus_rdata  register bus
//            cmd_err                  one-cycle protocol error pulse
//            busy                     high whenever the FSM is not idle
module uart_cmd_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    output logic       cmd_err,
    output logic       busy
);

    state_t     state;
    state_t     state_next;
    logic       is_write;

    logic       rd_uart_c;
    logic       cmd_err_c;
    logic       op_load;
    logic       addr_load;
    logic       data_load;
    logic       rsp_load;
    logic [7:0] rsp_next;
    logic       timer_clear;
    logic       timer_enable;
    logic       timer_expired;

    bridge_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            w_data    <= 8'h00;
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
        end else begin
            state <= state_next;
            if (op_load) begin
                is_write <= (r_data == OP_WRITE);
            end
            if (addr_load) begin
                bus_addr <= r_data;
            end
            if (data_load) begin
                bus_wdata <= r_data;
            end
            if (rsp_load) begin
                w_data <= rsp_next;
            end
        end
    end

    always_comb begin
        state_next   = state;
        rd_uart_c    = 1'b0;
        cmd_err_c    = 1'b0;
        op_load      = 1'b0;
        addr_load    = 1'b0;
        data_load    = 1'b0;
        rsp_load     = 1'b0;
        rsp_next     = w_data;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_empty) begin
                    rd_uart_c = 1'b1;
                    if ((r_data == OP_WRITE) || (r_data == OP_READ)) begin
                        op_load     = 1'b1;
                        timer_clear = 1'b1;
                        state_next  = GET_ADDR;
                    end else begin
                        cmd_err_c  = 1'b1;
                        rsp_load   = 1'b1;
                        rsp_next   = RSP_ERR;
                        state_next = SEND;
                    end
                end
            end

            GET_ADDR: begin
                if (!rx_empty) begin
                    rd_uart_c = 1'b1;
                    addr_load = 1'b1;
                    if (is_write) begin
                        timer_clear = 1'b1;
                        state_next  = GET_DATA;
                    end else begin
                        state_next  = BUS_RD;
                    end
                end else begin
                    timer_enable = 1'b1;
                    if (timer_expired) begin
                        cmd_err_c  = 1'b1;
                        rsp_load   = 1'b1;
                        rsp_next   = RSP_ERR;
                        state_next = SEND;
                    end
                end
            end

            GET_DATA: begin
                if (!rx_empty) begin
                    rd_uart_c  = 1'b1;
                    data_load  = 1'b1;
                    state_next = BUS_WR;
                end else begin
                    timer_enable = 1'b1;
                    if (timer_expired) begin
                        cmd_err_c  = 1'b1;
                        rsp_load   = 1'b1;
                        rsp_next   = RSP_ERR;
                        state_next = SEND;
                    end
                end
            end

            BUS_WR: begin
                rsp_load   = 1'b1;
                rsp_next   = RSP_ACK;
                state_next = SEND;
            end

            BUS_RD: begin
                state_next = RD_WAIT;
            end

            // bus_rdata is valid here, one cycle after the bus_re strobe.
            RD_WAIT: begin
                rsp_load   = 1'b1;
                rsp_next   = bus_rdata;
                state_next = SEND;
            end

            SEND: begin
                if (!tx_full) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The pop and error pulse are decoded from live FIFO inputs, so they are
    // masked during reset to keep the FIFO untouched while rst is held.
    assign rd_uart = rd_uart_c & ~rst;
    assign cmd_err = cmd_err_c & ~rst;
    assign wr_uart = (state == SEND) && !tx_full;
    assign bus_we  = (state == BUS_WR);
    assign bus_re  = (state == BUS_RD);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb/tb_uart_cmd_bridge.sv - self-checking bench for uart_cmd_bridge
module tb_uart_cmd_bridge;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic       tx_full = 1'b0;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata = 8'h00;
    logic       cmd_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_cmd_bridge #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .cmd_err   (cmd_err),
        .busy      (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Environment: receive FIFO, transmit log, register bus memory.
    logic [7:0] rxq[$];
    logic [7:0] mem[256];
    int         cyc = 0;
    int         pop_cyc[$];
    int         we_cyc[$];
    logic [7:0] we_addr[$];
    logic [7:0] we_data[$];
    int         re_cyc[$];
    logic [7:0] re_addr[$];
    int         tx_cyc[$];
    logic [7:0] tx_byte[$];
    int         err_cyc[$];
    bit         pop_req = 0;
    bit         rd_req = 0;
    logic [7:0] rd_a = 8'h00;
    bit         rand_full = 0;

    always @(negedge clk) begin
        cyc++;
        if (rd_uart) begin
            chk("rd_uart_when_empty", 32'(rx_empty), 32'd0);
            pop_cyc.push_back(cyc);
            pop_req = 1;
        end
        if (bus_we) begin
            we_cyc.push_back(cyc);
            we_addr.push_back(bus_addr);
            we_data.push_back(bus_wdata);
            mem[bus_addr] = bus_wdata;
        end
        if (bus_re) begin
            re_cyc.push_back(cyc);
            re_addr.push_back(bus_addr);
            rd_req = 1;
            rd_a = bus_addr;
        end
        if (wr_uart) begin
            tx_cyc.push_back(cyc);
            tx_byte.push_back(w_data);
        end
        if (cmd_err) begin
            err_cyc.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        #1;
        if (pop_req && rxq.size() > 0) begin
            void'(rxq.pop_front());
        end
        pop_req = 0;
        bus_rdata = rd_req ? mem[rd_a] : 8'($urandom);
        rd_req = 0;
        if (rand_full) begin
            tx_full = ($urandom_range(0, 3) == 0);
        end
        rx_empty = (rxq.size() == 0);
        r_data = rx_empty ? 8'($urandom) : rxq[0];
    end

    task automatic clear_logs();
        pop_cyc.delete(); we_cyc.delete(); we_addr.delete(); we_data.delete();
        re_cyc.delete(); re_addr.delete(); tx_cyc.delete(); tx_byte.delete();
        err_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int k = 0;
        while (tx_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(tx_cyc.size() >= n), 32'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_strobes"}, {26'd0, rd_uart, wr_uart, bus_we, bus_re, cmd_err, busy}, 32'd0);
        chk({tag, "_regs"}, {8'd0, w_data, bus_addr, bus_wdata}, 32'd0);
    endtask

    logic [7:0] ref_mem[256];
    logic [7:0] exp_rsp[$];

    initial begin
        logic [7:0] w0;
        bit         stable;
        int         k;
        int         nwe;
        int         nre;
        int         nerr;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        rst = 1'b1;
        idle(3);
        check_reset_outs("reset");
        rst = 1'b0;
        idle(2);

        // Write frame.
        clear_logs();
        rxq.push_back(8'h57); rxq.push_back(8'h12); rxq.push_back(8'hA5);
        wait_tx(1, 60, "wr_done");
        idle(4);
        chk("wr_pops", pop_cyc.size(), 3);
        chk("wr_we_count", we_cyc.size(), 1);
        chk("wr_addr", we_addr[0], 8'h12);
        chk("wr_data", we_data[0], 8'hA5);
        chk("wr_rsp", tx_byte[0], 8'h4B);
        chk("wr_tx_count", tx_cyc.size(), 1);
        chk("wr_latency", tx_cyc[0] - pop_cyc[2], 2);
        chk("wr_re_count", re_cyc.size(), 0);
        chk("wr_busy_after", busy, 0);

        // Read frame.
        mem[8'h12] = 8'h3C;
        clear_logs();
        rxq.push_back(8'h52); rxq.push_back(8'h12);
        wait_tx(1, 60, "rd_done");
        idle(4);
        chk("rd_re_count", re_cyc.size(), 1);
        chk("rd_addr", re_addr[0], 8'h12);
        chk("rd_rsp", tx_byte[0], 8'h3C);
        chk("rd_latency", tx_cyc[0] - pop_cyc[1], 3);
        chk("rd_we_count", we_cyc.size(), 0);

        // Bad opcode followed by a good read.
        mem[8'h05] = 8'h9D;
        clear_logs();
        rxq.push_back(8'h41); rxq.push_back(8'h52); rxq.push_back(8'h05);
        wait_tx(2, 80, "bad_done");
        idle(4);
        chk("bad_err_count", err_cyc.size(), 1);
        chk("bad_err_at_pop", err_cyc[0], pop_cyc[0]);
        chk("bad_rsp", tx_byte[0], 8'h3F);
        chk("bad_next_rsp", tx_byte[1], 8'h9D);
        chk("bad_we_count", we_cyc.size(), 0);
        chk("bad_re_count", re_cyc.size(), 1);
        chk("bad_re_addr", re_addr[0], 8'h05);

        // Inter-byte timeout after a lone opcode.
        clear_logs();
        rxq.push_back(8'h57);
        wait_tx(1, 100, "to_done");
        idle(3);
        chk("to_err_count", err_cyc.size(), 1);
        chk("to_delay", err_cyc[0] - pop_cyc[0], TO);
        chk("to_rsp", tx_byte[0], 8'h3F);
        chk("to_send_delay", tx_cyc[0] - err_cyc[0], 1);
        chk("to_we_count", we_cyc.size(), 0);
        chk("to_busy_after", busy, 0);

        // Back-pressure from the transmit FIFO.
        clear_logs();
        tx_full = 1'b1;
        rxq.push_back(8'h57); rxq.push_back(8'h20); rxq.push_back(8'h11);
        k = 0;
        while (we_cyc.size() < 1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("bp_we_seen", we_cyc.size(), 1);
        idle(1);
        w0 = w_data;
        stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (w_data !== w0) stable = 0;
        end
        chk("bp_no_tx", tx_cyc.size(), 0);
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_wdata", w0, 8'h4B);
        chk("bp_busy", busy, 1);
        tx_full = 1'b0;
        idle(4);
        chk("bp_tx_count", tx_cyc.size(), 1);
        chk("bp_rsp", tx_byte[0], 8'h4B);

        // Reset in the middle of a write frame.
        clear_logs();
        rxq.push_back(8'h57); rxq.push_back(8'h12);
        k = 0;
        while (pop_cyc.size() < 2 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("mid_pops", pop_cyc.size(), 2);
        idle(3);
        rst = 1'b1;
        idle(2);
        check_reset_outs("mid_reset");
        rst = 1'b0;
        idle(20);
        chk("mid_no_we", we_cyc.size(), 0);
        chk("mid_no_tx", tx_cyc.size(), 0);
        chk("mid_no_err", err_cyc.size(), 0);
        mem[8'h07] = 8'h6E;
        rxq.push_back(8'h52); rxq.push_back(8'h07);
        wait_tx(1, 60, "mid_rd_done");
        idle(4);
        chk("mid_rd_rsp", tx_byte[0], 8'h6E);
        chk("mid_rd_addr", re_addr[0], 8'h07);
        chk("mid_re_count", re_cyc.size(), 1);
        chk("mid_we_count", we_cyc.size(), 0);

        // Randomised frame stream against a frame-level reference model.
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        clear_logs();
        exp_rsp.delete();
        nwe = 0; nre = 0; nerr = 0;
        for (int f = 0; f < 40; f++) begin
            int         kind;
            logic [7:0] a;
            logic [7:0] d;
            logic [7:0] b;
            kind = $urandom_range(0, 4);
            a = 8'($urandom_range(0, 7));
            d = 8'($urandom);
            if (kind <= 1) begin
                rxq.push_back(8'h57); rxq.push_back(a); rxq.push_back(d);
                ref_mem[a] = d;
                exp_rsp.push_back(8'h4B);
                nwe++;
            end else if (kind <= 3) begin
                rxq.push_back(8'h52); rxq.push_back(a);
                exp_rsp.push_back(ref_mem[a]);
                nre++;
            end else begin
                b = 8'($urandom);
                while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
                rxq.push_back(b);
                exp_rsp.push_back(8'h3F);
                nerr++;
            end
        end
        rand_full = 1;
        wait_tx(exp_rsp.size(), 8000, "rand_done");
        rand_full = 0;
        @(negedge clk);
        tx_full = 1'b0;
        idle(6);
        chk("rand_tx_count", tx_cyc.size(), exp_rsp.size());
        chk("rand_we_count", we_cyc.size(), nwe);
        chk("rand_re_count", re_cyc.size(), nre);
        chk("rand_err_count", err_cyc.size(), nerr);
        for (int i = 0; i < exp_rsp.size(); i++) begin
            chk($sformatf("rand_rsp%0d", i), tx_byte[i], exp_rsp[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
